// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Per-frame sprite motion controller for the maze game. Once per frame tick it
//   decodes a WASD keycode into a facing direction and a fixed step, refuses
//   moves into walls flagged by the maze collision logic, and runs a timed
//   bounce-back when a wall is hit while moving. It also provides the sprite
//   pixel-hit test and the start/end-zone flags.
//
// Ports
//   Clk, Reset_n        system clock, asynchronous active-low reset
//   frame_clk           vsync-rate frame clock (asynchronous to Clk)
//   restart             reload start position, back to IDLE (level)
//   enable              sprite active; when low, state and position hold
//   keycode[7:0]        04=A(left) 07=D(right) 1A=W(up) 16=S(down)
//   blk_L/R/U/D         wall adjacent on that side, sampled on the tick cycle
//   DrawX, DrawY        current VGA pixel
//   sprite_x, sprite_y  sprite top-left corner
//   rel_x, rel_y        DrawX/DrawY minus sprite position (mod 1024)
//   dir[1:0]            facing direction 0=L 1=R 2=U 3=D
//   moving, bouncing    FSM is in MOVE / BOUNCE
//   spr_pix             current pixel lies inside the sprite
//   at_start, at_end    sprite is in the start / end zone (only while enabled)
module sprite_motion_ctrl #(
  parameter int SPR_W         = 20,
  parameter int SPR_H         = 20,
  parameter int STEP          = 1,
  parameter int START_X       = 336,
  parameter int START_Y       = 33,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 639,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 479,
  parameter int BOUNCE_FRAMES = 4,
  parameter int START_LINE    = 64,
  parameter int END_LINE      = 416
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       restart,
  input  logic       enable,
  input  logic [7:0] keycode,
  input  logic       blk_L,
  input  logic       blk_R,
  input  logic       blk_U,
  input  logic       blk_D,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic [9:0] rel_x,
  output logic [9:0] rel_y,
  output logic [1:0] dir,
  output logic       moving,
  output logic       bouncing,
  output logic       spr_pix,
  output logic       at_start,
  output logic       at_end
);

  localparam int X_HI = X_MAX - SPR_W + 1;
  localparam int Y_HI = Y_MAX - SPR_H + 1;
  localparam int CW   = (BOUNCE_FRAMES > 1) ? $clog2(BOUNCE_FRAMES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_BOUNCE} state_t;
  typedef enum logic [1:0] {DIR_L = 2'd0, DIR_R = 2'd1, DIR_U = 2'd2, DIR_D = 2'd3} dir_t;

  state_t        state, nxt_state;
  dir_t          cur_dir, nxt_dir, key_dir, mv_dir;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [9:0]    pos_x, pos_y, x_nxt, y_nxt;
  logic          key_valid, key_blk, do_move;
  logic          fs1, fs2, fs3, tick;
  logic signed [10:0] x_s, y_s;

  // Frame tick: two-flop synchroniser, edge detect, then a registered pulse so
  // the tick lands three Clk cycles after the frame_clk rising edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs1  <= 1'b0;
      fs2  <= 1'b0;
      fs3  <= 1'b0;
      tick <= 1'b0;
    end else begin
      fs1  <= frame_clk;
      fs2  <= fs1;
      fs3  <= fs2;
      tick <= fs2 & ~fs3;
    end
  end

  // Key decode; the blocked flag is the wall on the side the key points to.
  always_comb begin
    key_valid = 1'b0;
    key_dir   = DIR_D;
    case (keycode)
      8'h04: begin key_valid = 1'b1; key_dir = DIR_L; end
      8'h07: begin key_valid = 1'b1; key_dir = DIR_R; end
      8'h1A: begin key_valid = 1'b1; key_dir = DIR_U; end
      8'h16: begin key_valid = 1'b1; key_dir = DIR_D; end
      default: begin key_valid = 1'b0; key_dir = DIR_D; end
    endcase
    case (key_dir)
      DIR_L:   key_blk = blk_L;
      DIR_R:   key_blk = blk_R;
      DIR_U:   key_blk = blk_U;
      default: key_blk = blk_D;
    endcase
  end

  // Next-state decision for one tick. Flipping bit 0 of the direction code
  // gives the opposite direction (L<->R, U<->D).
  always_comb begin
    nxt_state = state;
    nxt_dir   = cur_dir;
    nxt_cnt   = cnt;
    do_move   = 1'b0;
    mv_dir    = cur_dir;
    case (state)
      S_IDLE: begin
        if (key_valid) begin
          nxt_dir = key_dir;
          if (!key_blk) begin
            do_move   = 1'b1;
            mv_dir    = key_dir;
            nxt_state = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        if (!key_valid) begin
          nxt_state = S_IDLE;
        end else if (key_blk) begin
          // The entry step is the first of BOUNCE_FRAMES reverse steps.
          do_move   = 1'b1;
          mv_dir    = dir_t'(cur_dir ^ 2'b01);
          nxt_cnt   = CW'(BOUNCE_FRAMES - 1);
          nxt_state = (BOUNCE_FRAMES > 1) ? S_BOUNCE : S_IDLE;
        end else begin
          nxt_dir = key_dir;
          do_move = 1'b1;
          mv_dir  = key_dir;
        end
      end
      S_BOUNCE: begin
        do_move = 1'b1;
        mv_dir  = dir_t'(cur_dir ^ 2'b01);
        if (cnt <= CW'(1)) begin
          nxt_cnt   = '0;
          nxt_state = S_IDLE;
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Step in 11-bit signed space so a step past either edge saturates rather
  // than wrapping through 0/1023.
  always_comb begin
    x_s = $signed({1'b0, pos_x});
    y_s = $signed({1'b0, pos_y});
    if (do_move) begin
      case (mv_dir)
        DIR_L:   x_s = x_s - 11'(STEP);
        DIR_R:   x_s = x_s + 11'(STEP);
        DIR_U:   y_s = y_s - 11'(STEP);
        default: y_s = y_s + 11'(STEP);
      endcase
    end
    if (x_s < 11'(X_MIN))      x_nxt = 10'(X_MIN);
    else if (x_s > 11'(X_HI))  x_nxt = 10'(X_HI);
    else                       x_nxt = x_s[9:0];
    if (y_s < 11'(Y_MIN))      y_nxt = 10'(Y_MIN);
    else if (y_s > 11'(Y_HI))  y_nxt = 10'(Y_HI);
    else                       y_nxt = y_s[9:0];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x   <= 10'(START_X);
      pos_y   <= 10'(START_Y);
      cur_dir <= DIR_D;
      state   <= S_IDLE;
      cnt     <= '0;
    end else if (restart) begin
      pos_x <= 10'(START_X);
      pos_y <= 10'(START_Y);
      state <= S_IDLE;
      cnt   <= '0;
    end else if (enable && tick) begin
      pos_x   <= x_nxt;
      pos_y   <= y_nxt;
      cur_dir <= nxt_dir;
      state   <= nxt_state;
      cnt     <= nxt_cnt;
    end
  end

  assign sprite_x = pos_x;
  assign sprite_y = pos_y;
  assign dir      = cur_dir;
  assign moving   = (state == S_MOVE);
  assign bouncing = (state == S_BOUNCE);

  // Pixels left of / above the sprite wrap to large values and fail the test.
  assign rel_x    = DrawX - pos_x;
  assign rel_y    = DrawY - pos_y;
  assign spr_pix  = (rel_x < 10'(SPR_W)) && (rel_y < 10'(SPR_H));

  assign at_start = enable && (pos_y < 10'(START_LINE));
  assign at_end   = enable && (pos_y > 10'(END_LINE));

endmodule
